// File: rtl/rpn_stack_calc.sv
// Stack calculator: a LIFO of WIDTH-bit words driven by a valid/ready command port.
// ADD/SUB/SWAP read their two operands over a three-state FSM; all other commands complete in one cycle.
module rpn_stack_calc #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_opcode,
   input  logic [WIDTH-1:0] cmd_data,
   output logic [WIDTH-1:0] top,
   output logic [CNT_W-1:0] depth,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             carry,
   output logic [3:0]       error
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_PUSH  = 4'd1;
   localparam logic [3:0] OP_PEEK  = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_SWAP  = 4'd4;
   localparam logic [3:0] OP_POP   = 4'd5;
   localparam logic [3:0] OP_SUB   = 4'd6;
   localparam logic [3:0] OP_DUP   = 4'd7;
   localparam logic [3:0] OP_CLEAR = 4'd8;

   localparam logic [3:0] ERR_NONE = 4'd0;
   localparam logic [3:0] ERR_OVF  = 4'd1;
   localparam logic [3:0] ERR_UND  = 4'd2;
   localparam logic [3:0] ERR_ILL  = 4'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_WB} state_t;

   state_t           state_q, state_d;
   logic             ready_q, ready_d;
   logic [CNT_W-1:0] depth_q, depth_d;
   logic             full_q, full_d, empty_q, empty_d;
   logic [WIDTH-1:0] top_q, top_d, result_q, result_d;
   logic             rv_q, rv_d, carry_q, carry_d;
   logic [3:0]       err_q, err_d;
   logic [WIDTH-1:0] stk_q [DEPTH];
   logic [WIDTH-1:0] stk_d [DEPTH];
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [3:0]       op_q, op_d;

   logic [CNT_W-1:0] cnt_dec, cnt_dec2;
   logic [IDX_W-1:0] ia, ib, ip;
   logic [WIDTH:0]   alu;

   assign cnt_dec  = depth_q - CNT_W'(1);
   assign cnt_dec2 = depth_q - CNT_W'(2);
   assign ia       = cnt_dec[IDX_W-1:0];
   assign ib       = cnt_dec2[IDX_W-1:0];
   assign ip       = depth_q[IDX_W-1:0];
   // Bit WIDTH is the carry-out for ADD and the borrow (b<a) for SUB.
   assign alu      = (op_q == OP_SUB) ? ({1'b0, b_q} - {1'b0, a_q})
                                      : ({1'b0, b_q} + {1'b0, a_q});

   always_comb begin
      state_d  = state_q;
      depth_d  = depth_q;
      top_d    = top_q;
      result_d = result_q;
      rv_d     = 1'b0;
      carry_d  = carry_q;
      err_d    = err_q;
      stk_d    = stk_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && ready_q) begin
               case (cmd_opcode)
                  OP_NOP: ;
                  OP_PUSH: begin
                     if (full_q) err_d = ERR_OVF;
                     else begin
                        stk_d[ip] = cmd_data;
                        depth_d   = depth_q + CNT_W'(1);
                        top_d     = cmd_data;
                     end
                  end
                  OP_PEEK, OP_POP: begin
                     if (empty_q) err_d = ERR_UND;
                     else begin
                        result_d = top_q;
                        rv_d     = 1'b1;
                        if (cmd_opcode == OP_POP) begin
                           depth_d = cnt_dec;
                           top_d   = (depth_q >= CNT_W'(2)) ? stk_q[ib] : '0;
                        end
                     end
                  end
                  OP_DUP: begin
                     if (empty_q)     err_d = ERR_UND;
                     else if (full_q) err_d = ERR_OVF;
                     else begin
                        stk_d[ip] = top_q;
                        depth_d   = depth_q + CNT_W'(1);
                     end
                  end
                  OP_CLEAR: begin
                     depth_d = '0;
                     top_d   = '0;
                     err_d   = ERR_NONE;
                  end
                  OP_ADD, OP_SUB, OP_SWAP: begin
                     if (depth_q < CNT_W'(2)) err_d = ERR_UND;
                     else begin
                        a_d     = stk_q[ia];
                        op_d    = cmd_opcode;
                        state_d = ST_FETCH;
                     end
                  end
                  default: err_d = ERR_ILL;
               endcase
            end
         end
         ST_FETCH: begin
            b_d     = stk_q[ib];
            state_d = ST_WB;
         end
         ST_WB: begin
            if (op_q == OP_SWAP) begin
               stk_d[ia] = b_q;
               stk_d[ib] = a_q;
               top_d     = b_q;
            end else begin
               stk_d[ib] = alu[WIDTH-1:0];
               top_d     = alu[WIDTH-1:0];
               carry_d   = alu[WIDTH];
               depth_d   = cnt_dec;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      full_d  = (depth_d == CNT_W'(DEPTH));
      empty_d = (depth_d == '0);
      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         ready_q  <= 1'b0;
         depth_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         top_q    <= '0;
         result_q <= '0;
         rv_q     <= 1'b0;
         carry_q  <= 1'b0;
         err_q    <= ERR_NONE;
      end else begin
         state_q  <= state_d;
         ready_q  <= ready_d;
         depth_q  <= depth_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         top_q    <= top_d;
         result_q <= result_d;
         rv_q     <= rv_d;
         carry_q  <= carry_d;
         err_q    <= err_d;
      end
   end

   // Storage and operand latches need no reset: depth==0 marks every entry invalid.
   always_ff @(posedge clock) begin
      stk_q <= stk_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
   end

   assign cmd_ready    = ready_q;
   assign top          = top_q;
   assign depth        = depth_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign result       = result_q;
   assign result_valid = rv_q;
   assign carry        = carry_q;
   assign error        = err_q;
endmodule

// File: tb/tb_rpn_stack_calc.sv
// Directed bench for rpn_stack_calc (WIDTH=16, DEPTH=4); expected values are hand-computed.
module tb_rpn_stack_calc;
   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [3:0]       cmd_opcode = 4'd0;
   logic [WIDTH-1:0] cmd_data = '0;
   logic [WIDTH-1:0] top;
   logic [CNT_W-1:0] depth;
   logic             full, empty;
   logic [WIDTH-1:0] result;
   logic             result_valid, carry;
   logic [3:0]       error;

   int checks = 0;
   int failures = 0;

   rpn_stack_calc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_data(cmd_data),
      .top(top), .depth(depth), .full(full), .empty(empty),
      .result(result), .result_valid(result_valid),
      .carry(carry), .error(error)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk(tag, {31'd0, cmd_ready}, 32'd1);
   endtask

   // Returns 1 time unit after the accepting edge.
   task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] d);
      wait_ready("ready_before_cmd");
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_data   = d;
      step();
      cmd_valid  = 1'b0;
      cmd_data   = 16'hDEAD;
   endtask

   initial begin
      reset = 1'b0;
      repeat (3) step();
      chk("rst_depth", depth, 0);
      chk("rst_top", top, 0);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_error", error, 0);
      chk("rst_carry", carry, 0);
      chk("rst_result", result, 0);
      chk("rst_rv", result_valid, 0);
      chk("rst_empty", empty, 1);
      reset = 1'b1;
      step();
      chk("ready_after_release", cmd_ready, 1);

      // 5 + 7, with the back-pressure window
      send(4'd1, 16'd5);
      send(4'd1, 16'd7);
      send(4'd3, 16'd0);
      chk("add_busy1", cmd_ready, 0);
      step();
      chk("add_busy2", cmd_ready, 0);
      step();
      chk("add_ready_n3", cmd_ready, 1);
      chk("add_depth", depth, 1);
      chk("add_top", top, 12);
      chk("add_carry", carry, 0);

      send(4'd8, 16'd0);
      send(4'd1, 16'hFFFF);
      send(4'd1, 16'h0002);
      send(4'd3, 16'd0);
      wait_ready("add2_done");
      chk("addc_top", top, 16'h0001);
      chk("addc_carry", carry, 1);

      send(4'd8, 16'd0);
      send(4'd1, 16'd3);
      send(4'd1, 16'd9);
      send(4'd6, 16'd0);
      wait_ready("sub_done");
      chk("sub_top", top, 16'hFFFA);
      chk("sub_carry", carry, 1);
      chk("sub_depth", depth, 1);

      send(4'd8, 16'd0);
      send(4'd1, 16'd3);
      send(4'd1, 16'd9);
      send(4'd4, 16'd0);
      wait_ready("swap_done");
      chk("swap_top", top, 3);
      chk("swap_depth", depth, 2);
      chk("swap_carry_kept", carry, 1);
      send(4'd5, 16'd0);
      chk("pop_result", result, 3);
      chk("pop_rv", result_valid, 1);
      chk("pop_top", top, 9);
      chk("pop_depth", depth, 1);
      step();
      chk("pop_rv_pulse", result_valid, 0);

      send(4'd8, 16'd0);
      send(4'd1, 16'h0055);
      send(4'd7, 16'd0);
      chk("dup_depth", depth, 2);
      chk("dup_top", top, 16'h0055);
      send(4'd2, 16'd0);
      chk("peek_result", result, 16'h0055);
      chk("peek_rv", result_valid, 1);
      chk("peek_depth", depth, 2);

      send(4'd8, 16'd0);
      send(4'd1, 16'd1);
      send(4'd1, 16'd2);
      send(4'd1, 16'd3);
      send(4'd1, 16'd4);
      chk("full_set", full, 1);
      send(4'd1, 16'd5);
      chk("ovf_error", error, 1);
      chk("ovf_depth", depth, 4);
      chk("ovf_top", top, 4);
      send(4'd8, 16'd0);
      chk("clr_error", error, 0);
      chk("clr_empty", empty, 1);
      chk("clr_top", top, 0);
      chk("clr_full", full, 0);

      send(4'd5, 16'd0);
      chk("und_error", error, 2);
      chk("und_rv", result_valid, 0);
      chk("und_result_kept", result, 16'h0055);
      send(4'd12, 16'd0);
      chk("ill_error", error, 3);
      send(4'd1, 16'd6);
      send(4'd6, 16'd0);
      chk("sub1_error", error, 2);
      chk("sub1_ready", cmd_ready, 1);
      chk("sub1_depth", depth, 1);
      chk("sub1_top", top, 6);

      // Reset arriving while ADD is in flight
      send(4'd8, 16'd0);
      send(4'd1, 16'd2);
      send(4'd1, 16'd3);
      send(4'd3, 16'd0);
      reset = 1'b0;
      step();
      chk("midrst_depth", depth, 0);
      chk("midrst_error", error, 0);
      chk("midrst_carry", carry, 0);
      chk("midrst_ready", cmd_ready, 0);
      chk("midrst_top", top, 0);
      reset = 1'b1;
      step();
      chk("midrst_ready_back", cmd_ready, 1);
      send(4'd1, 16'd8);
      chk("post_rst_depth", depth, 1);
      chk("post_rst_top", top, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
